// File: rtl/gcd_rr_scheduler_if.sv
// ---------------------------------------------------------------------------
// gcd_rr_scheduler_if
// Bundles every non-clock signal of the GCD round-robin scheduler.
//   Client side   : req, op_a, op_b (in)  / ack, result_valid, result,
//                   result_id, busy (out)
//   Datapath side : lt, eq, gt, dp_a_out (in) / data_in, ldA, ldB, sel1,
//                   sel2, sel_in (out)
//   Optional      : iter_count (out) when GCD_ITER_CNT_EN is defined
// Modports:
//   master - environment (clients + GCD datapath) driving the scheduler
//   slave  - the scheduler itself
// ---------------------------------------------------------------------------
interface gcd_rr_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] op_a;
  logic [N_REQ*WIDTH-1:0] op_b;
  logic [N_REQ-1:0]       ack;
  logic                   result_valid;
  logic [WIDTH-1:0]       result;
  logic [ID_W-1:0]        result_id;
  logic                   busy;
  logic [WIDTH-1:0]       data_in;
  logic                   ldA;
  logic                   ldB;
  logic                   sel1;
  logic                   sel2;
  logic                   sel_in;
  logic                   lt;
  logic                   eq;
  logic                   gt;
  logic [WIDTH-1:0]       dp_a_out;

`ifdef GCD_ITER_CNT_EN
  logic [15:0]            iter_count;

  modport master (
    output req, op_a, op_b, lt, eq, gt, dp_a_out,
    input  ack, result_valid, result, result_id, busy,
           data_in, ldA, ldB, sel1, sel2, sel_in, iter_count
  );

  modport slave (
    input  req, op_a, op_b, lt, eq, gt, dp_a_out,
    output ack, result_valid, result, result_id, busy,
           data_in, ldA, ldB, sel1, sel2, sel_in, iter_count
  );
`else
  modport master (
    output req, op_a, op_b, lt, eq, gt, dp_a_out,
    input  ack, result_valid, result, result_id, busy,
           data_in, ldA, ldB, sel1, sel2, sel_in
  );

  modport slave (
    input  req, op_a, op_b, lt, eq, gt, dp_a_out,
    output ack, result_valid, result, result_id, busy,
           data_in, ldA, ldB, sel1, sel2, sel_in
  );
`endif

endinterface

// File: rtl/gcd_rr_scheduler.sv
// ---------------------------------------------------------------------------
// gcd_rr_scheduler
// Round-robin scheduler/sequencer sharing one repeated-subtraction GCD
// datapath (registers A/B, muxes X/Y, subtractor, load mux, comparator)
// among N_REQ requesters. One job is in flight at a time; the result is
// returned tagged with the requester id.
//
// Ports:
//   clock    - sole clock, all state updates on posedge
//   reset_n  - synchronous active-low reset
//   bus      - gcd_rr_scheduler_if.slave carrying:
//     req/op_a/op_b        client job requests and packed operands
//     ack                  one-hot, one-cycle accept pulse
//     result_valid/result/result_id  one-cycle tagged result
//     busy                 high whenever the FSM is not IDLE
//     data_in/ldA/ldB/sel1/sel2/sel_in  datapath controls
//     lt/eq/gt/dp_a_out    datapath status (combinational from A/B)
//
// Optional feature macro: GCD_ITER_CNT_EN
//   When defined, bus.iter_count reports the number of subtractions
//   performed for the job just returned (saturating at 16'hFFFF).
// ---------------------------------------------------------------------------
module gcd_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int ID_W  = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  gcd_rr_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    ITER,
    RESP
  } state_t;

  state_t           state_q;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  win_q;
  logic             zero_q;
  logic [WIDTH-1:0] lat_a_q;
  logic [WIDTH-1:0] lat_b_q;

  logic [N_REQ-1:0] ack_q;
  logic             result_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [ID_W-1:0]  result_id_q;
  logic             busy_q;

  logic             grant_vld_d;
  logic [ID_W-1:0]  grant_id_d;
  logic [WIDTH-1:0] win_a_d;
  logic [WIDTH-1:0] win_b_d;
  int               idx;

  logic [WIDTH-1:0] data_in_d;
  logic             ldA_d;
  logic             ldB_d;
  logic             sel1_d;
  logic             sel2_d;
  logic             sel_in_d;

`ifdef GCD_ITER_CNT_EN
  logic [15:0]      iter_count_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  // Round-robin search: walk offsets from the top down so the smallest
  // offset from the pointer is the last (and therefore winning) match.
  always_comb begin
    grant_vld_d = 1'b0;
    grant_id_d  = '0;
    idx         = 0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      idx = int'(ptr_q) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (1'(bus.req >> idx)) begin
        grant_vld_d = 1'b1;
        grant_id_d  = ID_W'(idx);
      end
    end
  end

  // Operand slice of the candidate winner.
  always_comb begin
    win_a_d = WIDTH'(bus.op_a >> (int'(grant_id_d) * WIDTH));
    win_b_d = WIDTH'(bus.op_b >> (int'(grant_id_d) * WIDTH));
  end

  // Operand latches are pure data; they are only meaningful once a job
  // has been accepted, so they carry no reset.
  always_ff @(posedge clock) begin
    if (state_q == IDLE && grant_vld_d) begin
      lat_a_q <= win_a_d;
      lat_b_q <= win_b_d;
    end
  end

  // Main sequencer with registered client-facing outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      win_q          <= '0;
      zero_q         <= 1'b0;
      ack_q          <= '0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      result_id_q    <= '0;
      busy_q         <= 1'b0;
`ifdef GCD_ITER_CNT_EN
      iter_count_q   <= '0;
`endif
    end else begin
      ack_q          <= '0;
      result_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_vld_d) begin
            ack_q   <= N_REQ'(1) << grant_id_d;
            win_q   <= grant_id_d;
            zero_q  <= (win_a_d == '0) || (win_b_d == '0);
            busy_q  <= 1'b1;
            state_q <= LOAD_A;
`ifdef GCD_ITER_CNT_EN
            iter_count_q <= '0;
`endif
          end
        end
        LOAD_A: state_q <= LOAD_B;
        LOAD_B: state_q <= ITER;
        ITER: begin
          // A zero operand would never converge by subtraction, so it
          // short-circuits: gcd(x,0)=x and gcd(0,0)=0 both equal A|B.
          if (zero_q) begin
            result_q    <= lat_a_q | lat_b_q;
            result_id_q <= win_q;
            state_q     <= RESP;
          end else if (bus.eq) begin
            result_q    <= bus.dp_a_out;
            result_id_q <= win_q;
            state_q     <= RESP;
          end else if (bus.lt || bus.gt) begin
`ifdef GCD_ITER_CNT_EN
            iter_count_q <= sat_inc16(iter_count_q);
`endif
          end
        end
        RESP: begin
          result_valid_q <= 1'b1;
          busy_q         <= 1'b0;
          ptr_q          <= (win_q == ID_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
          state_q        <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Datapath controls: decoded from state, plus the comparator in ITER.
  // X = sel1 ? B : A, Y = sel2 ? B : A, subtractor computes X - Y, so the
  // larger register always loses the smaller and never underflows.
  always_comb begin
    data_in_d = '0;
    ldA_d     = 1'b0;
    ldB_d     = 1'b0;
    sel1_d    = 1'b0;
    sel2_d    = 1'b0;
    sel_in_d  = 1'b0;
    case (state_q)
      LOAD_A: begin
        data_in_d = lat_a_q;
        sel_in_d  = 1'b1;
        ldA_d     = 1'b1;
      end
      LOAD_B: begin
        data_in_d = lat_b_q;
        sel_in_d  = 1'b1;
        ldB_d     = 1'b1;
      end
      ITER: begin
        if (!zero_q && !bus.eq) begin
          if (bus.lt) begin
            sel1_d = 1'b1;
            ldB_d  = 1'b1;
          end else if (bus.gt) begin
            sel2_d = 1'b1;
            ldA_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.ack          = ack_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result       = result_q;
  assign bus.result_id    = result_id_q;
  assign bus.busy         = busy_q;
  assign bus.data_in      = data_in_d;
  assign bus.ldA          = ldA_d;
  assign bus.ldB          = ldB_d;
  assign bus.sel1         = sel1_d;
  assign bus.sel2         = sel2_d;
  assign bus.sel_in       = sel_in_d;
`ifdef GCD_ITER_CNT_EN
  assign bus.iter_count   = iter_count_q;
`endif

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_gcd_rr_scheduler
// Self-checking bench: a behavioural GCD datapath closes the loop around
// the scheduler, a scoreboard queue holds the expected (id, result,
// subtraction count) per job, and a negedge monitor checks ack order,
// load sequencing, latency and results.
// ---------------------------------------------------------------------------
module tb_gcd_rr_scheduler;

  localparam int N_REQ = 4;
  localparam int WIDTH = 16;
  localparam int ID_W  = 2;

  typedef struct {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    int               k;
  } exp_t;

  logic clk;
  logic rst_n;

  gcd_rr_scheduler_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dif ();

  gcd_rr_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath
  logic [WIDTH-1:0] rA, rB, dX, dY, dmux;
  initial begin
    rA = '0;
    rB = '0;
  end
  always_comb begin
    dX   = dif.sel1 ? rB : rA;
    dY   = dif.sel2 ? rB : rA;
    dmux = dif.sel_in ? dif.data_in : (dX - dY);
  end
  always @(posedge clk) begin
    if (dif.ldA) rA <= dmux;
    if (dif.ldB) rB <= dmux;
  end
  assign dif.lt       = rA < rB;
  assign dif.eq       = rA == rB;
  assign dif.gt       = rA > rB;
  assign dif.dp_a_out = rA;

  // Client operand registers
  logic [WIDTH-1:0] opa_arr [N_REQ];
  logic [WIDTH-1:0] opb_arr [N_REQ];
  always_comb begin
    dif.op_a = '0;
    dif.op_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      dif.op_a[i*WIDTH +: WIDTH] = opa_arr[i];
      dif.op_b[i*WIDTH +: WIDTH] = opb_arr[i];
    end
  end

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t cur;
  int   cyc = 0;
  int   t_ack = 0;
  int   t_rv = 0;
  int   dt = 0;
  int   last_gap = -1;
  bit   have_rv = 1'b0;
  bit   in_flight = 1'b0;
  bit   mon_en = 1'b0;
  int   ack_cnt = 0;
  int   done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic void gcd_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    output logic [WIDTH-1:0] r, output int k);
    logic [WIDTH-1:0] x, y;
    x = a;
    y = b;
    k = 0;
    if (a == '0 || b == '0) begin
      r = a | b;
    end else begin
      while (x != y) begin
        if (x > y) x = x - y;
        else       y = y - x;
        k++;
      end
      r = x;
    end
  endfunction

  task automatic push_job(input logic [ID_W-1:0] id, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
    exp_t e;
    opa_arr[id] = a;
    opb_arr[id] = b;
    e.id = id;
    e.a  = a;
    e.b  = b;
    gcd_model(a, b, e.res, e.k);
    exp_q.push_back(e);
  endtask

  task automatic wait_acks(input int target);
    int n;
    n = 0;
    while (ack_cnt < target && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (ack_cnt < target) chk("ack_timeout", 32'(ack_cnt), 32'(target));
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt < target) chk("done_timeout", 32'(done_cnt), 32'(target));
  endtask

  task automatic run_job(input logic [ID_W-1:0] id, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
    int base_a, base_d;
    base_a = ack_cnt;
    base_d = done_cnt;
    push_job(id, a, b);
    dif.req[id] = 1'b1;
    wait_acks(base_a + 1);
    dif.req[id] = 1'b0;
    wait_done(base_d + 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},    32'(dif.ack), 0);
    chk({tag, "_rv"},     32'(dif.result_valid), 0);
    chk({tag, "_res"},    32'(dif.result), 0);
    chk({tag, "_rid"},    32'(dif.result_id), 0);
    chk({tag, "_busy"},   32'(dif.busy), 0);
    chk({tag, "_din"},    32'(dif.data_in), 0);
    chk({tag, "_ctl"},    32'({dif.ldA, dif.ldB, dif.sel1, dif.sel2, dif.sel_in}), 0);
`ifdef GCD_ITER_CNT_EN
    chk({tag, "_icnt"},   32'(dif.iter_count), 0);
`endif
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!mon_en) continue;
      if (!rst_n) begin
        in_flight = 1'b0;
        continue;
      end
      if (dif.ack != '0) begin
        if (exp_q.size() == 0) begin
          chk("ack_unexp", 32'(dif.ack), 0);
        end else begin
          cur = exp_q.pop_front();
          chk("ack_id", 32'(dif.ack), 32'(4'b0001 << cur.id));
          if (have_rv) last_gap = cyc - t_rv;
          t_ack     = cyc;
          in_flight = 1'b1;
          ack_cnt++;
        end
      end
      if (in_flight) begin
        dt = cyc - t_ack;
        if (dt == 0) begin
          chk("ldA_load", 32'({dif.ldA, dif.sel_in}), 3);
          chk("din_a", 32'(dif.data_in), 32'(cur.a));
        end else if (dt == 1) begin
          chk("ldB_load", 32'({dif.ldB, dif.sel_in}), 3);
          chk("din_b", 32'(dif.data_in), 32'(cur.b));
        end else if (!dif.result_valid) begin
          if (cur.k == 0) chk("iter_noload", 32'({dif.ldA, dif.ldB}), 0);
          else            chk("one_sub", 32'(dif.ldA & dif.ldB), 0);
        end
        if (!dif.result_valid) chk("busy_hi", 32'(dif.busy), 1);
      end
      if (dif.result_valid) begin
        if (!in_flight) begin
          chk("rv_unexp", 32'(dif.result_valid), 0);
        end else begin
          chk("result", 32'(dif.result), 32'(cur.res));
          chk("result_id", 32'(dif.result_id), 32'(cur.id));
          chk("latency", 32'(cyc - t_ack), 32'(4 + cur.k));
          chk("busy_lo", 32'(dif.busy), 0);
`ifdef GCD_ITER_CNT_EN
          chk("iter_count", 32'(dif.iter_count), 32'(cur.k));
`endif
          in_flight = 1'b0;
          t_rv      = cyc;
          have_rv   = 1'b1;
          done_cnt++;
        end
      end
    end
  end

  initial begin
    int base_a, base_d, saved;
    logic [ID_W-1:0] rid;
    rst_n   = 1'b0;
    dif.req = '0;
    for (int i = 0; i < N_REQ; i++) begin
      opa_arr[i] = '0;
      opb_arr[i] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Directed jobs
    run_job(2'd0, 16'd143, 16'd78);
    run_job(2'd1, 16'd12, 16'd12);
    run_job(2'd2, 16'd0, 16'd25);
    run_job(2'd3, 16'd40, 16'd0);
    run_job(2'd0, 16'd0, 16'd0);

    // Reset and check all four requesters arbitrate 0,1,2,3
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    base_a = ack_cnt;
    base_d = done_cnt;
    push_job(2'd0, 16'd48, 16'd18);
    push_job(2'd1, 16'd35, 16'd21);
    push_job(2'd2, 16'd7, 16'd5);
    push_job(2'd3, 16'd100, 16'd75);
    dif.req = 4'b1111;
    for (int n = 0; n < 400 && ack_cnt < base_a + 4; n++) begin
      @(negedge clk); #1;
      dif.req = dif.req & ~dif.ack;
    end
    dif.req = '0;
    wait_done(base_d + 4);

    // Pointer moves past 1, so 3 wins over 0
    run_job(2'd1, 16'd9, 16'd3);
    base_a = ack_cnt;
    base_d = done_cnt;
    push_job(2'd3, 16'd27, 16'd18);
    push_job(2'd0, 16'd14, 16'd49);
    dif.req = 4'b1001;
    for (int n = 0; n < 400 && ack_cnt < base_a + 2; n++) begin
      @(negedge clk); #1;
      dif.req = dif.req & ~dif.ack;
    end
    dif.req = '0;
    wait_done(base_d + 2);

    // Random jobs
    for (int j = 0; j < 6; j++) begin
      rid = ID_W'($urandom_range(N_REQ - 1, 0));
      run_job(rid, WIDTH'($urandom_range(200, 1)), WIDTH'($urandom_range(200, 1)));
    end

    // Back-to-back with req[0] held high
    base_a = ack_cnt;
    base_d = done_cnt;
    push_job(2'd0, 16'd9, 16'd6);
    push_job(2'd0, 16'd9, 16'd6);
    dif.req[0] = 1'b1;
    wait_acks(base_a + 2);
    dif.req[0] = 1'b0;
    wait_done(base_d + 2);
    chk("b2b_gap", 32'(last_gap), 1);

    // Reset mid-ITER aborts silently
    base_a = ack_cnt;
    push_job(2'd1, 16'd1000, 16'd1);
    dif.req[1] = 1'b1;
    wait_acks(base_a + 1);
    dif.req[1] = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    saved = done_cnt;
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk_all_zero("midrst");
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    chk("no_rv_after_rst", 32'(done_cnt), 32'(saved));
    run_job(2'd2, 16'd84, 16'd36);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gcd_rr_scheduler.md
Name: gcd_rr_scheduler

Overview:
- Round-robin scheduler and sequencer that shares one repeated-subtraction GCD datapath among N_REQ requesters.
- Accepts one operand-pair job at a time and drives the datapath load and mux controls: two registers A and B, operand muxes X and Y, a subtractor, a load mux, and an lt/eq/gt comparator.
- Returns the result tagged with the requester id. Sits between client blocks and the GCD datapath instance.

Parameters:
- N_REQ, 4, number of requesters.
- WIDTH, 16, operand/result width; matches datapath bus width.
- ID_W, 2, requester id width; 2**ID_W >= N_REQ required.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset (sampled on posedge clock).
- req  in  N_REQ  per-requester job request; held high until acked.
- op_a  in  N_REQ*WIDTH  packed operand A; requester i at [i*WIDTH +: WIDTH].
- op_b  in  N_REQ*WIDTH  packed operand B, same packing.
- ack  out  N_REQ  one-hot, one-cycle pulse: job accepted, operands sampled.
- result_valid  out  1  one-cycle pulse: result/result_id valid.
- result  out  WIDTH  GCD result.
- result_id  out  ID_W  requester that owns result.
- busy  out  1  high in every state except IDLE.
- data_in  out  WIDTH  operand to datapath load mux.
- ldA, ldB  out  1 each  register load enables.
- sel1, sel2, sel_in  out  1 each  mux selects (sel_in=1 selects data_in).
- lt, eq, gt  in  1 each  comparator outputs (A vs B), combinational from registers.
- dp_a_out  in  WIDTH  datapath register A output.

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE, rr pointer=0; ack, result_valid, result, result_id, busy, data_in, ldA, ldB, sel1, sel2, sel_in all 0. Reset mid-job aborts it silently, with no result_valid.
- Registered outputs: ack, result_valid, result, result_id, busy. Datapath controls are decoded from state, plus lt/gt in ITER.
- IDLE:
  - If any req is set, grant the first set bit searching upward from the pointer, wrapping at N_REQ-1.
  - Latch the winner's op_a/op_b and id, pulse ack[winner], go to LOAD_A.
  - zero_flag = (op_a==0)|(op_b==0).
- LOAD_A: data_in=latched A, sel_in=1, ldA=1 -> LOAD_B.
- LOAD_B: data_in=latched B, sel_in=1, ldB=1 -> ITER.
- ITER, priority order:
  - zero_flag: -> RESP with result = A|B (gcd(x,0)=x, gcd(0,0)=0); no loads.
  - eq: -> RESP with result = dp_a_out.
  - lt: sel1=1, sel2=0, sel_in=0, ldB=1 (B<=B-A); stay.
  - gt: sel1=0, sel2=1, sel_in=0, ldA=1 (A<=A-B); stay.
  - Exactly one subtraction per ITER cycle.
- RESP: result_valid=1 for one cycle with result and result_id; pointer <= winner+1 mod N_REQ -> IDLE.
- Latency, ack at cycle T with k subtractions: result_valid at T+4+k. Zero-operand jobs: T+4.
- Controls not listed for a state are 0. No result backpressure. Requests arriving while busy wait, with no ack.
- A req dropped before ack is legal and is not served. Widths: unsigned WIDTH-bit arithmetic; no overflow is possible because subtraction always takes the smaller operand from the larger.

Optional Feature:
- Macro GCD_ITER_CNT_EN.
- When defined: adds output iter_count [15:0]. It is cleared on accept, increments once per subtraction, saturates at 16'hFFFF, and is valid alongside result_valid. Reset value 0.
- When undefined: the port and the counter are absent; behaviour is otherwise identical.

Test Plan:
- Single job, req[0] with A=143, B=78: ack[0] at T, result_valid at T+10, result=13, result_id=0, iter_count=6.
- Equal operands 12/12 on req[1]: result=12 at T+4, iter_count=0, ldA/ldB never high in ITER.
- Zero cases: (0,25) -> 25; (40,0) -> 40; (0,0) -> 0; each at T+4, with no datapath loads after LOAD_B.
- Arbitration: all four req high after reset with distinct pairs -> acks in order 0,1,2,3. Then after id 1 is served, req[0] and req[3] both high -> 3 served before 0.
- Reset mid-ITER on job 1000/1 -> next posedge all outputs 0, busy=0, no result_valid. A following req[2] is acked and served normally.
- Back-to-back: req[0] held continuously -> the next ack comes exactly one cycle after result_valid.
